// File: rtl/frodo_top_seq_if.sv
// -----------------------------------------------------------------------------
// frodo_top_seq_if
// Run-request / instruction bus between a host and the FrodoKEM sequencer.
//
// Signals:
//   level      host -> seq  security level (00=640, 01=976, 10=1344, 11=invalid)
//   mode_ctrl  host -> seq  operation (00=keygen, 01=encaps, 10=decaps, 11=invalid)
//   start      host -> seq  run request, only looked at while the sequencer is idle
//   inst       seq -> host  current instruction word, zero when nothing is issued
//   inst_valid seq -> host  one-cycle strobe per issued instruction
//   busy       seq -> host  a run is in progress
//   done       seq -> host  one-cycle pulse on successful completion
//   timeout    seq -> host  one-cycle pulse on watchdog abort
//   error      seq -> host  one-cycle pulse when a run request had an invalid selection
//
// Modports:
//   master  host side (drives the run request)
//   slave   sequencer side (drives the instruction stream and status)
// -----------------------------------------------------------------------------
interface frodo_top_seq_if #(
    parameter int unsigned INST_WIDTH = 28
) ();
    logic [1:0]            level;
    logic [1:0]            mode_ctrl;
    logic                  start;
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  busy;
    logic                  done;
    logic                  timeout;
    logic                  error;

    modport master (
        output level,
        output mode_ctrl,
        output start,
        input  inst,
        input  inst_valid,
        input  busy,
        input  done,
        input  timeout,
        input  error
    );

    modport slave (
        input  level,
        input  mode_ctrl,
        input  start,
        output inst,
        output inst_valid,
        output busy,
        output done,
        output timeout,
        output error
    );
endinterface

// File: rtl/frodo_top_seq.sv
// -----------------------------------------------------------------------------
// frodo_top_seq
// Top-level sequencer for the FrodoKEM accelerator. On an accepted start it picks
// a fixed microprogram from the latched level and mode, issues each instruction
// for one cycle and then waits out that instruction's execution latency before
// issuing the next one. A per-run watchdog aborts the run after TIME cycles.
//
// Ports:
//   clk   single clock, all logic on its rising edge
//   rstn  synchronous, active-low reset
//   bus   frodo_top_seq_if.slave: level, mode_ctrl, start in;
//         inst, inst_valid, busy, done, timeout, error out (all registered)
//
// Parameters:
//   INST_WIDTH  instruction bus width (field layout below assumes 28)
//   ADDR_WIDTH  memory address field width (12 fits the 28-bit layout)
//   TIME        watchdog limit in cycles per run
//
// Instruction layouts:
//   memory  {op[27:25], addr[24:13], length[12:7], port[6:5], 5'b0}
//   compute {op[27:25], A[24:21], B[20:17], C[16:13], m[12:11], 11'b0}
// -----------------------------------------------------------------------------
module frodo_top_seq #(
    parameter int unsigned INST_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned TIME       = 10000
) (
    input  logic           clk,
    input  logic           rstn,
    frodo_top_seq_if.slave bus
);

    localparam int unsigned CntW = $clog2(TIME + 1);

    typedef logic [INST_WIDTH-1:0] inst_t;
    // Longest latency is 100 cycles (decode), so 8 bits cover every instruction.
    typedef logic [7:0]            lat_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam logic [2:0] OpLoad  = 3'b000;
    localparam logic [2:0] OpStore = 3'b001;
    localparam logic [2:0] OpMulAb = 3'b100;
    localparam logic [2:0] OpMulBa = 3'b101;
    localparam logic [2:0] OpCode  = 3'b110;

    localparam logic [1:0] LvlInvalid  = 2'b11;
    localparam logic [1:0] ModeKeygen  = 2'b00;
    localparam logic [1:0] ModeEncaps  = 2'b01;
    localparam logic [1:0] ModeInvalid = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] AddrIn     = ADDR_WIDTH'(12'h000);
    localparam logic [ADDR_WIDTH-1:0] AddrKeygen = ADDR_WIDTH'(12'h100);
    localparam logic [ADDR_WIDTH-1:0] AddrEncaps = ADDR_WIDTH'(12'h200);
    localparam logic [ADDR_WIDTH-1:0] AddrDecaps = ADDR_WIDTH'(12'h300);

    // -------------------------------------------------------------------------
    // Instruction construction
    // -------------------------------------------------------------------------
    function automatic inst_t mem_inst(input logic [2:0]            op,
                                       input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [5:0]            len,
                                       input logic [1:0]            port);
        return inst_t'({op, addr, len, port, 5'b0});
    endfunction

    function automatic inst_t cmp_inst(input logic [2:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b,
                                       input logic [3:0] c,
                                       input logic [1:0] m);
        return inst_t'({op, a, b, c, m, 11'b0});
    endfunction

    // Transfer length in 64-word blocks per security level.
    function automatic logic [5:0] blk_len(input logic [1:0] lvl);
        case (lvl)
            2'b00:   return 6'd10;
            2'b01:   return 6'd16;
            default: return 6'd21;
        endcase
    endfunction

    // Index of the final instruction of each program.
    function automatic logic [2:0] prog_last(input logic [1:0] mode);
        case (mode)
            ModeKeygen: return 3'd2;
            ModeEncaps: return 3'd4;
            default:    return 3'd3;
        endcase
    endfunction

    // Fixed microprograms. Invalid selections never reach here because they are
    // rejected at start acceptance; the default arm simply maps to decaps.
    function automatic inst_t prog_word(input logic [1:0] mode,
                                        input logic [1:0] lvl,
                                        input logic [2:0] pc);
        logic [5:0] len;
        inst_t      w;
        len = blk_len(lvl);
        w   = '0;
        case (mode)
            ModeKeygen: begin
                case (pc)
                    3'd0:    w = mem_inst(OpLoad, AddrIn, len, 2'd0);
                    3'd1:    w = cmp_inst(OpMulAb, 4'd1, 4'd2, 4'd3, 2'd0);
                    default: w = mem_inst(OpStore, AddrKeygen, len, 2'd1);
                endcase
            end
            ModeEncaps: begin
                case (pc)
                    3'd0:    w = mem_inst(OpLoad, AddrIn, len, 2'd0);
                    3'd1:    w = cmp_inst(OpMulBa, 4'd0, 4'd3, 4'd1, 2'd0);
                    3'd2:    w = cmp_inst(OpCode, 4'd0, 4'd0, 4'd2, 2'd0);
                    3'd3:    w = cmp_inst(OpMulAb, 4'd1, 4'd2, 4'd3, 2'd0);
                    default: w = mem_inst(OpStore, AddrEncaps, len, 2'd1);
                endcase
            end
            default: begin
                case (pc)
                    3'd0:    w = mem_inst(OpLoad, AddrIn, len, 2'd0);
                    3'd1:    w = cmp_inst(OpMulBa, 4'd0, 4'd3, 4'd1, 2'd0);
                    3'd2:    w = cmp_inst(OpCode, 4'd0, 4'd0, 4'd3, 2'd1);
                    default: w = mem_inst(OpStore, AddrDecaps, len, 2'd1);
                endcase
            end
        endcase
        return w;
    endfunction

    // Execution latency in cycles, counting the issue cycle itself.
    function automatic lat_t lat_of(input logic [2:0] op,
                                    input logic [5:0] len,
                                    input logic [1:0] m,
                                    input logic [1:0] lvl);
        lat_t lat;
        case (op)
            OpLoad, OpStore: lat = lat_t'(len) + lat_t'(2);
            OpMulAb, OpMulBa: begin
                case (lvl)
                    2'b00:   lat = lat_t'(40);
                    2'b01:   lat = lat_t'(61);
                    default: lat = lat_t'(84);
                endcase
            end
            default: lat = (m == 2'b00) ? lat_t'(30) : lat_t'(100);
        endcase
        return lat;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q;
    logic [1:0]      level_q;
    logic [1:0]      mode_q;
    logic [2:0]      pc_q;
    lat_t            rem_q;      // cycles left in the current instruction, incl. this one
    logic [CntW-1:0] run_cnt_q;  // equals the cycle number within the run
    inst_t           inst_q;
    logic            inst_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;
    logic            error_q;

    // -------------------------------------------------------------------------
    // Next-instruction lookahead
    // -------------------------------------------------------------------------
    inst_t start_word;
    lat_t  start_lat;
    inst_t next_word;
    lat_t  next_lat;
    logic  sel_invalid;
    logic  inst_last_cycle;
    logic  prog_end;
    logic  wd_expire;

    always_comb begin
        start_word = prog_word(bus.mode_ctrl, bus.level, 3'd0);
        start_lat  = lat_of(start_word[27:25], start_word[12:7], start_word[12:11], bus.level);
        next_word  = prog_word(mode_q, level_q, pc_q + 3'd1);
        next_lat   = lat_of(next_word[27:25], next_word[12:7], next_word[12:11], level_q);

        sel_invalid     = (bus.level == LvlInvalid) || (bus.mode_ctrl == ModeInvalid);
        inst_last_cycle = (rem_q == lat_t'(1));
        prog_end        = inst_last_cycle && (pc_q == prog_last(mode_q));
        // Counter reads TIME in the following cycle, which is when timeout shows.
        wd_expire       = (run_cnt_q >= CntW'(TIME - 1));
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            level_q      <= 2'b00;
            mode_q       <= 2'b00;
            pc_q         <= 3'd0;
            rem_q        <= '0;
            run_cnt_q    <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // Pulses and the instruction bus fall back to idle unless set below.
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            error_q      <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        level_q <= bus.level;
                        mode_q  <= bus.mode_ctrl;
                        if (sel_invalid) begin
                            error_q <= 1'b1;
                        end else begin
                            pc_q         <= 3'd0;
                            rem_q        <= start_lat;
                            run_cnt_q    <= CntW'(1);
                            inst_q       <= start_word;
                            inst_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= StIssue;
                        end
                    end
                end

                StIssue, StWait: begin
                    run_cnt_q <= run_cnt_q + CntW'(1);
                    // Completion takes priority over a coincident watchdog expiry.
                    if (prog_end) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (wd_expire) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else if (inst_last_cycle) begin
                        pc_q         <= pc_q + 3'd1;
                        rem_q        <= next_lat;
                        inst_q       <= next_word;
                        inst_valid_q <= 1'b1;
                        state_q      <= StIssue;
                    end else begin
                        rem_q   <= rem_q - lat_t'(1);
                        state_q <= StWait;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_frodo_top_seq.sv
// -----------------------------------------------------------------------------
// tb_frodo_top_seq
// Scoreboard bench for frodo_top_seq. Two instances share the clock and reset:
// u_dut with the default watchdog and u_dut_wd with TIME=100. Stimulus pushes
// hand-computed expected events (instruction issues, done, timeout, error) with
// their cycle numbers; a negedge monitor pops and compares whenever a DUT shows
// one, and checks busy against the expected busy window every cycle.
// -----------------------------------------------------------------------------
module tb_frodo_top_seq;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    frodo_top_seq_if #(.INST_WIDTH(28)) bus0 ();
    frodo_top_seq_if #(.INST_WIDTH(28)) bus1 ();

    frodo_top_seq #(
        .INST_WIDTH (28),
        .ADDR_WIDTH (12),
        .TIME       (10000)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus0)
    );

    frodo_top_seq #(
        .INST_WIDTH (28),
        .ADDR_WIDTH (12),
        .TIME       (100)
    ) u_dut_wd (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    typedef enum int {EvInst, EvDone, EvTimeout, EvError} ev_kind_e;
    typedef struct {
        int          dut;
        int          cyc;
        ev_kind_e    kind;
        logic [27:0] inst;
    } ev_t;

    ev_t sb[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_err    = 0;
    int  busy_lo[2] = '{1, 1};
    int  busy_hi[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int c, input ev_kind_e k, input logic [27:0] ins);
        ev_t e;
        e.dut  = d;
        e.cyc  = c;
        e.kind = k;
        e.inst = ins;
        sb.push_back(e);
    endtask

    task automatic match(input int d, input ev_kind_e k, input logic [27:0] ins);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected %s on dut%0d at cycle %0d (inst 0x%0h)", k.name(), d, cyc, ins);
            return;
        end
        e = sb.pop_front();
        check($sformatf("event_dut(%s)", k.name()), 64'(d), 64'(e.dut));
        check($sformatf("event_kind dut%0d", d), 64'(k), 64'(e.kind));
        check($sformatf("event_cycle %s dut%0d", k.name(), d), 64'(cyc), 64'(e.cyc));
        if (k == EvInst) check($sformatf("inst dut%0d", d), 64'(ins), 64'(e.inst));
    endtask

    task automatic observe(input int d, input logic v, input logic dn, input logic to,
                           input logic er, input logic bsy, input logic [27:0] ins);
        logic exp_busy;
        if (v)  match(d, EvInst, ins);
        if (dn) match(d, EvDone, '0);
        if (to) match(d, EvTimeout, '0);
        if (er) match(d, EvError, '0);
        exp_busy = (cyc >= busy_lo[d]) && (cyc <= busy_hi[d]);
        check($sformatf("busy dut%0d", d), 64'(bsy), 64'(exp_busy));
        if (!v) check($sformatf("inst_idle dut%0d", d), 64'(ins), 64'd0);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            observe(0, bus0.inst_valid, bus0.done, bus0.timeout, bus0.error, bus0.busy, bus0.inst);
            observe(1, bus1.inst_valid, bus1.done, bus1.timeout, bus1.error, bus1.busy, bus1.inst);
        end
    end

    task automatic check_zero(input int d);
        if (d == 0) begin
            check("reset_outputs dut0", {bus0.inst, bus0.inst_valid, bus0.busy, bus0.done,
                                         bus0.timeout, bus0.error}, 64'd0);
        end else begin
            check("reset_outputs dut1", {bus1.inst, bus1.inst_valid, bus1.busy, bus1.done,
                                         bus1.timeout, bus1.error}, 64'd0);
        end
    endtask

    // Called at a negedge: start is sampled by the next posedge, so cycle 1 of the
    // run is cyc+1. busy_end is the last cycle number with busy high (0 = never).
    task automatic launch(input int d, input logic [1:0] lvl, input logic [1:0] md,
                          input int busy_end);
        busy_lo[d] = cyc + 1;
        busy_hi[d] = cyc + busy_end;
        if (d == 0) begin
            bus0.level     = lvl;
            bus0.mode_ctrl = md;
            bus0.start     = 1'b1;
        end else begin
            bus1.level     = lvl;
            bus1.mode_ctrl = md;
            bus1.start     = 1'b1;
        end
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected events not seen, next due at cycle %0d",
                     sb.size(), sb[0].cyc);
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        bus0.level = 2'b00; bus0.mode_ctrl = 2'b00; bus0.start = 1'b0;
        bus1.level = 2'b00; bus1.mode_ctrl = 2'b00; bus1.start = 1'b0;
        rstn = 1'b0;

        // Reset held for 5 cycles.
        repeat (5) begin
            @(negedge clk);
            check_zero(0);
            check_zero(1);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Encaps, level 976 (L=16); a second start with changed inputs at cycle 50.
        base = cyc;
        push(0, base + 1,   EvInst, 28'h0000800);
        push(0, base + 19,  EvInst, 28'hA062000);
        push(0, base + 80,  EvInst, 28'hC004000);
        push(0, base + 110, EvInst, 28'h8246000);
        push(0, base + 171, EvInst, 28'h2400820);
        push(0, base + 189, EvDone, '0);
        launch(0, 2'b01, 2'b01, 188);
        while (cyc < base + 50) @(negedge clk);
        bus0.level     = 2'b11;
        bus0.mode_ctrl = 2'b10;
        bus0.start     = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        drain(300);

        // Decaps, level 1344 (L=21), full run.
        base = cyc;
        push(0, base + 1,   EvInst, 28'h0000A80);
        push(0, base + 24,  EvInst, 28'hA062000);
        push(0, base + 108, EvInst, 28'hC006800);
        push(0, base + 208, EvInst, 28'h2600AA0);
        push(0, base + 231, EvDone, '0);
        launch(0, 2'b10, 2'b10, 230);
        drain(300);

        // Decaps again, reset lands at cycle 60.
        base = cyc;
        push(0, base + 1,  EvInst, 28'h0000A80);
        push(0, base + 24, EvInst, 28'hA062000);
        launch(0, 2'b10, 2'b10, 59);
        while (cyc < base + 59) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_zero(0);
        @(negedge clk);
        check_zero(0);
        rstn = 1'b1;
        drain(5);

        // Keygen, level 640 (L=10), after the mid-run reset.
        base = cyc;
        push(0, base + 1,  EvInst, 28'h0000500);
        push(0, base + 13, EvInst, 28'h8246000);
        push(0, base + 53, EvInst, 28'h2200520);
        push(0, base + 65, EvDone, '0);
        launch(0, 2'b00, 2'b00, 64);
        drain(200);

        // Invalid level, then invalid mode.
        base = cyc;
        push(0, base + 1, EvError, '0);
        launch(0, 2'b11, 2'b00, 0);
        drain(20);
        base = cyc;
        push(0, base + 1, EvError, '0);
        launch(0, 2'b00, 2'b11, 0);
        drain(20);

        // Watchdog instance: encaps at level 1344 cannot finish in 100 cycles.
        base = cyc;
        push(1, base + 1,   EvInst,    28'h0000A80);
        push(1, base + 24,  EvInst,    28'hA062000);
        push(1, base + 100, EvTimeout, '0);
        launch(1, 2'b10, 2'b01, 99);
        drain(200);

        // Watchdog instance back in idle: a short keygen completes normally.
        base = cyc;
        push(1, base + 1,  EvInst, 28'h0000500);
        push(1, base + 13, EvInst, 28'h8246000);
        push(1, base + 53, EvInst, 28'h2200520);
        push(1, base + 65, EvDone, '0);
        launch(1, 2'b00, 2'b00, 64);
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
